// File: rtl/runtime_info_frame.sv
// runtime_info_frame: runtime-programmable HDMI InfoFrame source.
// Host fills a shadow payload and commits it. The PB0 checksum is then
// accumulated one byte per cycle, and the result is swapped into the
// active buffer only at a packet boundary, so a torn packet is never shown.
module runtime_info_frame #(
    parameter logic [6:0] TYPE    = 7'd3,
    parameter logic [7:0] VERSION = 8'd1,
    parameter logic [4:0] LENGTH  = 5'd25
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             commit,
    input  logic             packet_read,
    output logic             busy,
    output logic             valid,
    output logic [23:0]      header,
    output logic [3:0][55:0] sub
);
    localparam logic [7:0] HB0  = {1'b1, TYPE};
    localparam logic [7:0] HB1  = VERSION;
    localparam logic [7:0] HB2  = {3'b000, LENGTH};
    localparam logic [7:0] HSUM = HB0 + HB1 + HB2;

    typedef enum logic [1:0] {IDLE, SUM, PENDING} state_t;

    state_t          state_q;
    logic [7:0]      acc_q;
    logic [4:0]      idx_q;
    logic            busy_q;
    logic            valid_q;
    // Byte 0 of the shadow is never written; PB0 is filled with the checksum
    // on the swap. Bytes above LENGTH stay 0 because writes there are refused.
    logic [27:0][7:0] shadow_q;
    logic [27:0][7:0] active_q;

    logic [7:0] acc_d;
    logic [7:0] chk_d;
    logic       wr_ok;
    logic       swap;

    assign wr_ok = wr_en && !busy_q && (wr_addr != 5'd0) && (wr_addr <= LENGTH);
    assign acc_d = acc_q + shadow_q[idx_q];
    assign chk_d = (~acc_q) + 8'd1;
    // With no published packet there is nothing to tear, so swap at once.
    assign swap  = (state_q == PENDING) && (packet_read || !valid_q);

    // Host writes into the shadow payload while no commit is in flight.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
        end else if (wr_ok) begin
            shadow_q[wr_addr] <= wr_data;
        end
    end

    // Commit sequencer: checksum accumulation, then wait for a packet boundary.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            active_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (commit) begin
                        state_q <= SUM;
                        acc_q   <= HSUM;
                        idx_q   <= 5'd1;
                        busy_q  <= 1'b1;
                    end
                end
                SUM: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 5'd1;
                    if (idx_q == LENGTH) begin
                        state_q <= PENDING;
                    end
                end
                PENDING: begin
                    if (swap) begin
                        active_q    <= shadow_q;
                        active_q[0] <= chk_d;
                        valid_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign header = {HB2, HB1, HB0};
    assign sub    = active_q;
    assign busy   = busy_q;
    assign valid  = valid_q;
endmodule
